// File: rtl/frame_sequencer.sv
// Purpose: APU frame counter; divides clk into quarter/half-frame strobes and raises the frame IRQ.
// Latency: strobes and frame_step register one clk after the counter hits a step; $4017 applies 3 clk after reg_change toggles.
// Backpressure: none; free-running, strobes are single-cycle and cannot be stalled.
//
// Ports:
//   clk, rst_n            APU clock, asynchronous active-low reset
//   reg_4017[7:6]         mode (0: 4-step, 1: 5-step), IRQ inhibit; bits 5:0 unused
//   reg_change            toggles once per $4017 write, asynchronous to clk
//   irq_clear             one-clk pulse from a $4015 read, clears frame_irq
//   enable_240hz/_120hz   quarter-/half-frame strobes, one clk wide
//   frame_irq             frame interrupt level
//   frame_step            last step fired (0 after reset or reload)

`timescale 1ns/1ps

module frame_sequencer #(
    parameter int STEP1     = 7457,
    parameter int STEP2     = 14913,
    parameter int STEP3     = 22371,
    parameter int STEP4     = 29829,
    parameter int STEP5     = 37281,
    parameter int CNT_WIDTH = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] reg_4017,
    input  logic       reg_change,
    input  logic       irq_clear,
    output logic       enable_240hz,
    output logic       enable_120hz,
    output logic       frame_irq,
    output logic [2:0] frame_step
);

    typedef enum logic {
        MODE_4STEP = 1'b0,
        MODE_5STEP = 1'b1
    } mode_e;

    localparam logic [CNT_WIDTH-1:0] S1 = CNT_WIDTH'(STEP1);
    localparam logic [CNT_WIDTH-1:0] S2 = CNT_WIDTH'(STEP2);
    localparam logic [CNT_WIDTH-1:0] S3 = CNT_WIDTH'(STEP3);
    localparam logic [CNT_WIDTH-1:0] S4 = CNT_WIDTH'(STEP4);
    localparam logic [CNT_WIDTH-1:0] S5 = CNT_WIDTH'(STEP5);

    logic [1:0]           sync;
    logic                 reload;
    logic [CNT_WIDTH-1:0] cnt;
    mode_e                mode;
    logic                 inhibit;

    logic                 hit_q;
    logic                 hit_h;
    logic                 hit_irq;
    logic [2:0]           hit_step;
    logic                 seq_end;

    // Bits 5:0 of $4017 belong to other units.
    logic unused_bits;
    assign unused_bits = ^reg_4017[5:0];

    // Toggle handshake: any change of the synchronised level is one write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync   <= 2'b00;
            reload <= 1'b0;
        end else begin
            sync   <= {sync[0], reg_change};
            reload <= sync[1] ^ sync[0];
        end
    end

    // Step decode. In 5-step mode the counter runs straight through STEP4.
    always_comb begin
        hit_q    = 1'b0;
        hit_h    = 1'b0;
        hit_irq  = 1'b0;
        hit_step = 3'd0;
        seq_end  = 1'b0;
        if (cnt == S1) begin
            hit_q    = 1'b1;
            hit_step = 3'd1;
        end else if (cnt == S2) begin
            hit_q    = 1'b1;
            hit_h    = 1'b1;
            hit_step = 3'd2;
        end else if (cnt == S3) begin
            hit_q    = 1'b1;
            hit_step = 3'd3;
        end else if (cnt == S4 && mode == MODE_4STEP) begin
            hit_q    = 1'b1;
            hit_h    = 1'b1;
            hit_irq  = !inhibit;
            hit_step = 3'd4;
            seq_end  = 1'b1;
        end else if (cnt == S5 && mode == MODE_5STEP) begin
            hit_q    = 1'b1;
            hit_h    = 1'b1;
            hit_step = 3'd5;
            seq_end  = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt          <= '0;
            mode         <= MODE_4STEP;
            inhibit      <= 1'b0;
            enable_240hz <= 1'b0;
            enable_120hz <= 1'b0;
            frame_irq    <= 1'b0;
            frame_step   <= 3'd0;
        end else if (reload) begin
            // A write restarts the sequence and overrides any step landing this cycle.
            cnt          <= '0;
            mode         <= mode_e'(reg_4017[7]);
            inhibit      <= reg_4017[6];
            frame_step   <= 3'd0;
            // Entering 5-step mode clocks the units immediately.
            enable_240hz <= reg_4017[7];
            enable_120hz <= reg_4017[7];
            if (reg_4017[6] || irq_clear) begin
                frame_irq <= 1'b0;
            end
        end else begin
            cnt          <= seq_end ? '0 : cnt + CNT_WIDTH'(1);
            enable_240hz <= hit_q;
            enable_120hz <= hit_h;
            if (hit_step != 3'd0) begin
                frame_step <= hit_step;
            end
            // Setting wins over a coincident $4015 read.
            if (hit_irq) begin
                frame_irq <= 1'b1;
            end else if (irq_clear) begin
                frame_irq <= 1'b0;
            end
        end
    end

endmodule

// File: doc/frame_sequencer.md
Name: frame_sequencer

Overview:
- APU frame counter; sits directly upstream of the noise, pulse and triangle channels.
- Divides the 1.79 MHz APU clock into quarter-frame (`enable_240hz`) and half-frame (`enable_120hz`) strobes.
- These strobes drive the envelope, linear-counter, length-counter and sweep units. The block also raises the frame interrupt.
- Configured by $4017 through the same toggle-based clock-crossing handshake the channels use.

Parameters:
- STEP1, 7457: cycle count at which step 1 fires.
- STEP2, 14913: cycle count at which step 2 fires.
- STEP3, 22371: cycle count at which step 3 fires.
- STEP4, 29829: cycle count at which step 4 fires; wrap point in 4-step mode.
- STEP5, 37281: cycle count at which step 5 fires; wrap point in 5-step mode.
- CNT_WIDTH, 16: width of the cycle counter; must hold STEP5.

Ports:
- clk  input  1  APU clock, 1.79 MHz.
- rst_n  input  1  asynchronous active-low reset.
- reg_4017  input  8  $4017 contents. Bit 7 = mode (0: 4-step, 1: 5-step). Bit 6 = IRQ inhibit. Bits 5:0 ignored.
- reg_change  input  1  toggles once per $4017 write; asynchronous to clk.
- irq_clear  input  1  single-cycle synchronous pulse; a $4015 read clears the frame IRQ.
- enable_240hz  output  1  quarter-frame strobe, one clk wide.
- enable_120hz  output  1  half-frame strobe, one clk wide.
- frame_irq  output  1  frame interrupt flag, level.
- frame_step  output  3  index of the last step fired (0 after reset/reload, 1..5).

Behaviour:
- Reset (rst_n low, asynchronous):
  - cycle counter = 0, mode = 0, inhibit = 0.
  - sync flops = 0, reload = 0.
  - all outputs = 0.
- Input capture:
  - reg_change passes through a 2-flop synchroniser.
  - reload is registered as (sync[1] != sync[0]).
  - reload is high for exactly one clk, 3 clk after the toggle.
  - reg_4017 is sampled only on the reload cycle.
  - mode and inhibit are held in internal registers between writes.
- Cycle counter:
  - Increments by 1 every clk.
  - On the step that ends the sequence (STEP4 in mode 0, STEP5 in mode 1), it loads 0 instead of incrementing.
  - Period is STEP4+1 clk in mode 0 and STEP5+1 clk in mode 1.
- Step events: when the counter equals STEPk, the registered strobes below are high for the following clk only.
  - 4-step mode:
    - STEP1: quarter.
    - STEP2: quarter and half.
    - STEP3: quarter.
    - STEP4: quarter and half; frame_irq set if inhibit = 0.
  - 5-step mode:
    - STEP1: quarter.
    - STEP2: quarter and half.
    - STEP3: quarter.
    - STEP4: nothing (the counter passes it); frame_step stays 3.
    - STEP5: quarter and half; never sets IRQ.
  - frame_step updates to k on the same edge as the strobes.
- Reload cycle (takes priority over any step event in the same cycle):
  - counter <= 0.
  - mode <= reg_4017[7], inhibit <= reg_4017[6].
  - frame_step <= 0.
  - If reg_4017[6] = 1, frame_irq <= 0.
  - If reg_4017[7] = 1, enable_240hz and enable_120hz are both high for the next clk (immediate clock).
  - If reg_4017[7] = 0, no strobe is issued.
- IRQ flag:
  - Set only at a mode-0 STEP4 with inhibit = 0.
  - Cleared by irq_clear, or by a reload with bit 6 = 1.
  - If set and irq_clear coincide, set wins.
  - Otherwise frame_irq holds its value.
- The counter wraps only at the sequence end; it never overflows CNT_WIDTH.
- Mode change mid-sequence: takes effect only via reload, which restarts the counter at 0.
- rst_n asserted mid-sequence: all state returns to reset values immediately. After release, counting restarts in 4-step mode from 0.

Test Plan:
- Overrides STEP1..5 = 10, 20, 30, 40, 50 for sim speed.
- Reset release, no writes -> quarter strobes in the clk after counter = 10, 20, 30, 40. Half strobes after 20 and 40. frame_irq rises after 40. Sequence repeats with period 41 clk; frame_step cycles 1,2,3,4.
- Toggle reg_change with reg_4017 = 0x80 -> 3 clk later reload. The next clk has both strobes high. Subsequent quarter strobes follow counter 10, 20, 30, 50; half strobes follow 20, 50. Period is 51 clk; frame_irq stays 0.
- IRQ pending, pulse irq_clear -> frame_irq low next clk. Pulse irq_clear on the same clk frame_irq is being set -> frame_irq = 1.
- Toggle with reg_4017 = 0x40 while frame_irq = 1 -> frame_irq clears on reload. No strobe is issued, and no IRQ across 3 full 41-clk periods.
- Toggle reg_change so reload lands on a counter = 20 cycle -> no strobe from step 2; counter = 0 next clk.
- Assert rst_n low mid-sequence in 5-step mode -> outputs 0 immediately. After release, 4-step timing as in the first scenario.
